iterative_alu: RTL and testbench
================================

# iterative_alu

Registered execution unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a `DATA_WIDTH`-bit result over a valid/ready handshake. Logic, add/sub and compare operations complete in one cycle. Shifts are performed iteratively, one bit position per cycle, so no barrel shifter is needed. The unit sits in the execute stage between operand muxing and the result/branch-decision logic.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.
- `SHAMT_WIDTH`, default 5: shift-amount width; equals log2(`DATA_WIDTH`).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request this cycle.
- `Operation` input 4: operation code from the ALU controller.
- `SrcA` input `DATA_WIDTH`: operand A (shift source).
- `SrcB` input `DATA_WIDTH`: operand B; bits [`SHAMT_WIDTH`-1:0] give the shift amount.
- `out_valid` output 1: `ALUResult` holds a completed result.
- `out_ready` input 1: consumer takes the result this cycle.
- `ALUResult` output `DATA_WIDTH`: registered result.
- `busy` output 1: high while in SHIFT.

## Operation
Operation codes:
- 0000: AND
- 0001: OR
- 0010: pass `SrcB` (LUI)
- 0011: XOR
- 0100: SLL
- 0101: SRL
- 1101: SRA
- 0110: `SrcA` < `SrcB` signed (BLT)
- 0111: `SrcA` >= `SrcB` signed (BGE)
- 1000: `SrcA` == `SrcB` (BEQ)
- 1001: `SrcA` != `SrcB` (BNE)
- 1010: SUB
- 1011: ADD
- 1100: SLT (signed)
- 1110, 1111: result 0, no error.

Result formatting and arithmetic:
- Compare results are zero-extended 1/0.
- ADD and SUB wrap modulo 2^`DATA_WIDTH`; no carry or overflow output.

States:
- **IDLE**: `in_ready`=1.
  - On accept of a non-shift op, or a shift with amount 0: `ALUResult` is loaded and the next state is DONE. A zero-amount shift passes `SrcA` through unchanged.
  - On accept of a shift with amount k>0: the working register is loaded with `SrcA`, the counter with k, and the next state is SHIFT.
- **SHIFT**: each cycle the working register shifts by one bit and the counter decrements.
  - SLL inserts 0 at the LSB; SRL inserts 0 at the MSB; SRA replicates the MSB.
  - When the counter equals 1, that final shift lands in `ALUResult` and the next state is DONE.
  - `Operation` and operands are latched at accept; input changes during SHIFT are ignored.
- **DONE**: `out_valid`=1 and `ALUResult` is held stable until `out_ready`.
  - `in_ready` equals `out_ready`, so back-to-back acceptance is allowed.
  - `out_ready`=1 with `in_valid`=1: the new request is processed exactly as from IDLE in the same edge, with no bubble.
  - `out_ready`=1 with `in_valid`=0: next state is IDLE.

Reset values (asynchronous, any time):
- state = IDLE
- `ALUResult` = 0
- `out_valid` = 0
- `busy` = 0
- counter = 0
- `in_ready` = 1 once state is IDLE

A reset during SHIFT or DONE discards the in-flight operation; no result is delivered.

## Timing
- Non-shift or zero-amount shift: accepted at edge E0, `out_valid` high after E0 (1-cycle latency).
- Shift by k>0: `busy` high after E0 through edge E0+k−1; `out_valid` high after E0+k (k-cycle latency, maximum `DATA_WIDTH`−1).
- Throughput:
  - One non-shift op per cycle when `out_ready` is held high.
  - A shift of k blocks new acceptance for k cycles.
- `in_ready` is combinational from state and `out_ready`. No other output depends combinationally on inputs.
- Backpressure: `ALUResult` and `out_valid` are unchanged while `out_valid`=1 and `out_ready`=0.

## Test plan
- Reset then ADD: `SrcA`=0x7FFFFFFF, `SrcB`=1, op 1011 -> `ALUResult`=0x80000000, `out_valid` one cycle after accept. SUB 3−5 -> 0xFFFFFFFE.
- Compares: `SrcA`=0xFFFFFFFF, `SrcB`=1.
  - op 0110 -> 1.
  - op 0111 -> 0.
  - op 1100 -> 1.
  - op 1000 with equal operands -> 1.
  - op 1001 with equal operands -> 0.
- Shifts:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF, `out_valid` 31 cycles after accept, `busy` high 31 cycles.
  - SRL of the same -> 0x00000001.
  - SLL 0x1 by 4 -> 0x10 after 4 cycles.
  - Shift by 0 -> `SrcA` after 1 cycle.
- Backpressure: hold `out_ready`=0 for 5 cycles after an XOR 0xF0F0 ^ 0xFF00 -> `ALUResult`=0x0FF0 stable, `in_ready`=0. Then raise `out_ready` with a new AND queued -> the AND result appears the next cycle with no bubble.
- Reset mid-SHIFT: assert `reset` at cycle 3 of an SLL by 20 -> `out_valid`=0, `ALUResult`=0, `busy`=0 immediately. After release, an OR 0x5|0xA returns 0xF.
- Streaming: 8 back-to-back ops (AND, OR, LUI 0x12345000, XOR, op 1110, ADD, SUB, SLT) with `out_ready`=1 -> one result per cycle, op 1110 yields 0.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu
//   Registered execute-stage ALU with a valid/ready handshake on both sides.
//   Logic, add/sub and compare ops complete in one cycle; shifts walk one bit
//   position per cycle through a working register, so there is no barrel
//   shifter.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high
//   in_valid   in   request present
//   in_ready   out  request can be accepted this cycle (comb. from state, out_ready)
//   Operation  in   4-bit op code from the ALU controller
//   SrcA       in   operand A, shift source
//   SrcB       in   operand B, low SHAMT_WIDTH bits are the shift amount
//   out_valid  out  ALUResult holds a completed result
//   out_ready  in   consumer takes the result this cycle
//   ALUResult  out  registered result
//   busy       out  iterative shift in progress
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no result pending, ready for a request
// S_SHIFT | shifting one bit per cycle, counter holds remaining steps
// S_DONE  | ALUResult valid, held until out_ready
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  busy
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_LUI = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_BLT = 4'b0110;
  localparam logic [3:0] OP_BGE = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BNE = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_ADD = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]  work;
  logic [3:0]             op_q;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   start_shift;
  logic                   take;
  logic                   lt_signed;
  logic [DATA_WIDTH-1:0]  op_result;
  logic [DATA_WIDTH-1:0]  work_next;

  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign take     = in_valid && in_ready;

  assign shamt       = SrcB[SHAMT_WIDTH-1:0];
  assign is_shift    = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign lt_signed   = $signed(SrcA) < $signed(SrcB);

  // Single-cycle result. Shift ops only land here with a zero amount,
  // in which case SrcA passes through unchanged.
  always_comb begin
    op_result = '0;
    case (Operation)
      OP_AND:                 op_result = SrcA & SrcB;
      OP_OR:                  op_result = SrcA | SrcB;
      OP_LUI:                 op_result = SrcB;
      OP_XOR:                 op_result = SrcA ^ SrcB;
      OP_SLL, OP_SRL, OP_SRA: op_result = SrcA;
      OP_BLT:                 op_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      OP_BGE:                 op_result = {{(DATA_WIDTH-1){1'b0}}, ~lt_signed};
      OP_BEQ:                 op_result = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
      OP_BNE:                 op_result = {{(DATA_WIDTH-1){1'b0}}, SrcA != SrcB};
      OP_SUB:                 op_result = SrcA - SrcB;
      OP_ADD:                 op_result = SrcA + SrcB;
      OP_SLT:                 op_result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
      default:                op_result = '0;
    endcase
  end

  // One-bit step of the latched shift op.
  always_comb begin
    work_next = '0;
    case (op_q)
      OP_SLL:  work_next = {work[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  work_next = {1'b0, work[DATA_WIDTH-1:1]};
      default: work_next = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      work      <= '0;
      op_q      <= '0;
    end else if (take) begin
      // Accept path is shared by IDLE and DONE-with-out_ready, which gives
      // bubble-free back-to-back operation.
      op_q <= Operation;
      if (start_shift) begin
        work      <= SrcA;
        cnt       <= shamt;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        state     <= S_SHIFT;
      end else begin
        ALUResult <= op_result;
        out_valid <= 1'b1;
        state     <= S_DONE;
      end
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == SHAMT_WIDTH'(1)) begin
            ALUResult <= work_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            state     <= S_DONE;
          end else begin
            work <= work_next;
            cnt  <= cnt - SHAMT_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [3:0]    Operation = 4'd0;
  logic [DW-1:0] SrcA = '0;
  logic [DW-1:0] SrcB = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [DW-1:0] ALUResult;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [DW-1:0] expq[$];
  bit            rdy_rand = 1'b0;

  iterative_alu #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-word arithmetic straight from the op table.
  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    int unsigned k;
    logic lt;
    k  = b[4:0];
    lt = $signed(a) < $signed(b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return b;
      4'b0011: return a ^ b;
      4'b0100: return a << k;
      4'b0101: return a >> k;
      4'b1101: return $signed(a) >>> k;
      4'b0110: return DW'(lt);
      4'b0111: return DW'(!lt);
      4'b1000: return DW'(a == b);
      4'b1001: return DW'(a != b);
      4'b1010: return a - b;
      4'b1011: return a + b;
      4'b1100: return DW'(lt);
      default: return '0;
    endcase
  endfunction

  function automatic int shift_len(input logic [3:0] op, input logic [DW-1:0] b);
    if (op == 4'b0100 || op == 4'b0101 || op == 4'b1101) return int'(b[4:0]);
    return 0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out waiting on the DUT", name);
  endtask

  // Monitor: every consumed result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) check("result_without_request", DW'(expq.size()), DW'(1));
      else check("scoreboard", ALUResult, expq.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1 out_ready = ($urandom_range(3) != 0);
    end
  end

  // Called and returns at posedge+1; acc is the cyc value after the accept edge.
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      output int acc);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    acc       = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        expq.push_back(model(op, a, b));
        acc = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    timeout("send");
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency (edges after accept) and busy cycles.
  task automatic wait_out(input int acc, input int k, input string name,
                          input logic [DW-1:0] req);
    int  nb;
    bit  seen;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        nb++;
        check({name, "_in_ready_while_busy"}, DW'(in_ready), DW'(0));
      end
    end
    if (!seen) timeout(name);
    else begin
      check({name, "_latency"}, DW'(cyc - acc), DW'(k));
      check({name, "_busy_cycles"}, DW'(nb), DW'(k));
      check({name, "_busy_at_done"}, DW'(busy), DW'(0));
      check(name, ALUResult, req);
    end
    @(posedge clk);
    #1;
  endtask

  int            acc;
  int            accs[8];
  logic [3:0]    sops[8];
  logic [3:0]    rop;
  logic [DW-1:0] ra, rb;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", ALUResult, '0);
    check("reset_out_valid", DW'(out_valid), DW'(0));
    check("reset_busy", DW'(busy), DW'(0));
    check("reset_in_ready", DW'(in_ready), DW'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;

    send(4'b1011, 32'h7FFF_FFFF, 32'h1, acc);
    wait_out(acc, 0, "add_wrap", 32'h8000_0000);
    send(4'b1010, 32'd3, 32'd5, acc);
    wait_out(acc, 0, "sub", 32'hFFFF_FFFE);

    send(4'b0110, 32'hFFFF_FFFF, 32'h1, acc);
    wait_out(acc, 0, "blt", 32'h1);
    send(4'b0111, 32'hFFFF_FFFF, 32'h1, acc);
    wait_out(acc, 0, "bge", 32'h0);
    send(4'b1100, 32'hFFFF_FFFF, 32'h1, acc);
    wait_out(acc, 0, "slt", 32'h1);
    send(4'b1000, 32'h1234_5678, 32'h1234_5678, acc);
    wait_out(acc, 0, "beq", 32'h1);
    send(4'b1001, 32'h1234_5678, 32'h1234_5678, acc);
    wait_out(acc, 0, "bne", 32'h0);

    send(4'b1101, 32'h8000_0000, 32'd31, acc);
    wait_out(acc, 31, "sra31", 32'hFFFF_FFFF);
    send(4'b0101, 32'h8000_0000, 32'd31, acc);
    wait_out(acc, 31, "srl31", 32'h0000_0001);
    send(4'b0100, 32'h1, 32'd4, acc);
    wait_out(acc, 4, "sll4", 32'h10);
    send(4'b0100, 32'hA5A5_0001, 32'h100, acc);
    wait_out(acc, 0, "shift0", 32'hA5A5_0001);

    // Backpressure, then a queued AND accepted on the release edge.
    out_ready = 1'b0;
    send(4'b0011, 32'hF0F0, 32'hFF00, acc);
    Operation = 4'b0000;
    SrcA      = 32'hFFFF_00FF;
    SrcB      = 32'h0F0F_0F0F;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", ALUResult, 32'h0FF0);
      check("bp_out_valid", DW'(out_valid), DW'(1));
      check("bp_in_ready", DW'(in_ready), DW'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4'b0000, 32'hFFFF_00FF, 32'h0F0F_0F0F, acc);
    @(negedge clk);
    check("bp_and_no_bubble", DW'(cyc - acc), DW'(0));
    check("bp_and_valid", DW'(out_valid), DW'(1));
    check("bp_and_result", ALUResult, 32'h0F0F_000F);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift.
    send(4'b0100, 32'h1, 32'd20, acc);
    repeat (2) @(posedge clk);
    #1;
    check("mid_shift_busy", DW'(busy), DW'(1));
    reset = 1'b1;
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_result", ALUResult, '0);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    expq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    send(4'b0001, 32'h5, 32'hA, acc);
    wait_out(acc, 0, "or_after_reset", 32'hF);

    // Streaming: one accept per cycle with out_ready held high.
    sops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1110, 4'b1011, 4'b1010, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (sops[i] == 4'b0010) ? 32'h1234_5000 : $urandom;
      send(sops[i], ra, rb, accs[i]);
    end
    for (int i = 1; i < 8; i++) check("stream_accept_cycle", DW'(accs[i] - accs[0]), DW'(i));
    repeat (3) @(posedge clk);
    #1;
    check("stream_drained", DW'(expq.size()), DW'(0));

    // Random ops with random backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(15));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(3) == 0) rb = ra;
      if ($urandom_range(5) == 0) ra = 32'h8000_0000;
      send(rop, ra, rb, acc);
    end
    rdy_rand = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("random_drained", DW'(expq.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
